// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared types and constants for the DS1302 transaction scheduler.
//   state_e        - scheduler FSM states
//   *_ADDR_W       - DS1302 write-command addresses (read address = write + RD_OFS)
//   WP_ON / WP_OFF - write-protect register values
//   IDX_*          - byte index of each field inside the 56-bit time word
//   reg_addr()     - address of time field idx relative to a base command byte
package ds1302_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StRdBurst,
        StUpdate,
        StWait,
        StWpOff,
        StSet,
        StWpOn
    } state_e;

    localparam logic [7:0] SEC_ADDR_W     = 8'h80;
    localparam logic [7:0] WP_ADDR_W      = 8'h8E;
    localparam logic [7:0] TRICKLE_ADDR_W = 8'h90;
    localparam logic [7:0] RD_OFS         = 8'h01;

    localparam logic [7:0] WP_ON  = 8'h80;
    localparam logic [7:0] WP_OFF = 8'h00;

    localparam logic [2:0] IDX_SEC   = 3'd0;
    localparam logic [2:0] IDX_MIN   = 3'd1;
    localparam logic [2:0] IDX_HOUR  = 3'd2;
    localparam logic [2:0] IDX_DATE  = 3'd3;
    localparam logic [2:0] IDX_MONTH = 3'd4;
    localparam logic [2:0] IDX_WEEK  = 3'd5;
    localparam logic [2:0] IDX_YEAR  = 3'd6;

    // Clock/calendar registers sit on even command bytes, two apart.
    function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [2:0] idx);
        return base + {4'b0000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/ds1302_ctrl_if.sv
// ds1302_ctrl_if: single-register command bus between ds1302_ctrl and ds1302_io.
//   cmd_read / cmd_write        - command strobes, held until the matching ack
//   read_addr / write_addr      - command byte for the access
//   write_data                  - byte to write
//   cmd_read_ack / cmd_write_ack- one-cycle completion pulses
//   read_data                   - read result, valid in the cmd_read_ack cycle
// modport master: the scheduler side; modport slave: the ds1302_io side.
interface ds1302_ctrl_if;

    logic       cmd_read;
    logic       cmd_write;
    logic [7:0] read_addr;
    logic [7:0] write_addr;
    logic [7:0] write_data;
    logic       cmd_read_ack;
    logic       cmd_write_ack;
    logic [7:0] read_data;

    modport master (
        output cmd_read,
        output cmd_write,
        output read_addr,
        output write_addr,
        output write_data,
        input  cmd_read_ack,
        input  cmd_write_ack,
        input  read_data
    );

    modport slave (
        input  cmd_read,
        input  cmd_write,
        input  read_addr,
        input  write_addr,
        input  write_data,
        output cmd_read_ack,
        output cmd_write_ack,
        output read_data
    );

endinterface

// File: rtl/ds1302_poll_timer.sv
// ds1302_poll_timer: poll-interval counter.
//   clk, rst  - clock, synchronous active-low reset
//   clr_i     - return count to zero
//   en_i      - count while high
//   expired_o - high in the cycle the count reaches POLL_CYCLES-1 (while enabled)
module ds1302_poll_timer #(
    parameter int unsigned POLL_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(POLL_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/ds1302_ctrl.sv
// ds1302_ctrl: DS1302 transaction scheduler above ds1302_io.
// Polls the seven clock/calendar registers every POLL_CYCLES and publishes an atomic
// BCD snapshot; services user time-set requests as a WP-off / 7 writes / WP-on burst.
//   clk, rst   - clock, synchronous active-low reset
//   set_req    - level request to load set_time
//   set_time   - {year,week,month,date,hour,min,sec}, BCD bytes
//   set_ack    - one-cycle pulse when the set burst is complete
//   busy       - high whenever not waiting between polls
//   time_out   - last complete snapshot, same packing as set_time
//   time_valid - one-cycle pulse when time_out updates
//   io         - command bus to ds1302_io (master side)
// Optional: define DS1302_TRICKLE_INIT_EN to write TRICKLE_VAL to register 0x90 at boot.
module ds1302_ctrl
    import ds1302_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 5_000_000
`ifdef DS1302_TRICKLE_INIT_EN
    ,
    parameter logic [7:0]  TRICKLE_VAL = 8'hA5
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_req,
    input  logic [55:0]   set_time,
    output logic          set_ack,
    output logic          busy,
    output logic [55:0]   time_out,
    output logic          time_valid,
    ds1302_ctrl_if.master io
);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic        pend_q;
    logic [55:0] shadow_q;
    logic [55:0] hold_q;
    logic [55:0] time_out_q;
    logic        time_valid_q;
    logic        set_ack_q;
    logic        busy_q;
    logic        cmd_read_q;
    logic        cmd_write_q;
    logic [7:0]  read_addr_q;
    logic [7:0]  write_addr_q;
    logic [7:0]  write_data_q;

    logic poll_expired;
    logic cmd_idle;
    logic rd_done;
    logic wr_done;
    logic in_set;
    logic req_in;

    assign cmd_idle = !cmd_read_q && !cmd_write_q;
    assign rd_done  = cmd_read_q && io.cmd_read_ack;
    assign wr_done  = cmd_write_q && io.cmd_write_ack;
    assign in_set   = (state_q == StWpOff) || (state_q == StSet) || (state_q == StWpOn);
    // A level held through its own burst, or in the set_ack cycle, is not a new request.
    assign req_in   = set_req && !in_set && !set_ack_q;

    ds1302_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_poll_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != StWait),
        .en_i     (state_q == StWait),
        .expired_o(poll_expired)
    );

    // Commands are raised only from cmd_idle, so each drop is followed by one idle cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StBoot;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            shadow_q     <= '0;
            hold_q       <= '0;
            time_out_q   <= '0;
            time_valid_q <= 1'b0;
            set_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            time_valid_q <= 1'b0;
            set_ack_q    <= 1'b0;
            busy_q       <= 1'b1;
            if (req_in) begin
                pend_q <= 1'b1;
            end

            unique case (state_q)
                StBoot: begin
`ifdef DS1302_TRICKLE_INIT_EN
                    // idx 0: WP off, idx 1: trickle value, idx 2: WP on.
                    if (cmd_idle) begin
                        cmd_write_q <= 1'b1;
                        if (idx_q == 3'd0) begin
                            write_addr_q <= WP_ADDR_W;
                            write_data_q <= WP_OFF;
                        end else if (idx_q == 3'd1) begin
                            write_addr_q <= TRICKLE_ADDR_W;
                            write_data_q <= TRICKLE_VAL;
                        end else begin
                            write_addr_q <= WP_ADDR_W;
                            write_data_q <= WP_ON;
                        end
                    end else if (wr_done) begin
                        cmd_write_q <= 1'b0;
                        if (idx_q == 3'd2) begin
                            idx_q   <= IDX_SEC;
                            state_q <= StRdBurst;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
`else
                    idx_q   <= IDX_SEC;
                    state_q <= StRdBurst;
`endif
                end

                StRdBurst: begin
                    if (cmd_idle) begin
                        cmd_read_q  <= 1'b1;
                        read_addr_q <= reg_addr(SEC_ADDR_W + RD_OFS, idx_q);
                    end else if (rd_done) begin
                        cmd_read_q                   <= 1'b0;
                        shadow_q[{idx_q, 3'b000} +: 8] <= io.read_data;
                        if (idx_q == IDX_YEAR) begin
                            idx_q   <= IDX_SEC;
                            state_q <= StUpdate;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end

                StUpdate: begin
                    time_out_q   <= shadow_q;
                    time_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StWait;
                end

                StWait: begin
                    // A pending set wins over poll expiry.
                    if (pend_q || req_in) begin
                        pend_q  <= 1'b0;
                        hold_q  <= set_time;
                        state_q <= StWpOff;
                    end else if (poll_expired) begin
                        state_q <= StRdBurst;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                StWpOff: begin
                    if (cmd_idle) begin
                        cmd_write_q  <= 1'b1;
                        write_addr_q <= WP_ADDR_W;
                        write_data_q <= WP_OFF;
                    end else if (wr_done) begin
                        cmd_write_q <= 1'b0;
                        idx_q       <= IDX_SEC;
                        state_q     <= StSet;
                    end
                end

                StSet: begin
                    if (cmd_idle) begin
                        cmd_write_q  <= 1'b1;
                        write_addr_q <= reg_addr(SEC_ADDR_W, idx_q);
                        write_data_q <= hold_q[{idx_q, 3'b000} +: 8];
                    end else if (wr_done) begin
                        cmd_write_q <= 1'b0;
                        if (idx_q == IDX_YEAR) begin
                            idx_q   <= IDX_SEC;
                            state_q <= StWpOn;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end

                StWpOn: begin
                    if (cmd_idle) begin
                        cmd_write_q  <= 1'b1;
                        write_addr_q <= WP_ADDR_W;
                        write_data_q <= WP_ON;
                    end else if (wr_done) begin
                        cmd_write_q <= 1'b0;
                        set_ack_q   <= 1'b1;
                        state_q     <= StRdBurst;
                    end
                end

                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    assign set_ack       = set_ack_q;
    assign busy          = busy_q;
    assign time_out      = time_out_q;
    assign time_valid    = time_valid_q;
    assign io.cmd_read   = cmd_read_q;
    assign io.cmd_write  = cmd_write_q;
    assign io.read_addr  = read_addr_q;
    assign io.write_addr = write_addr_q;
    assign io.write_data = write_data_q;

endmodule

// File: tb/tb_ds1302_ctrl.sv
// tb_ds1302_ctrl: self-checking bench for ds1302_ctrl with a DS1302 bus model.
// Expected commands are queued by the stimulus and checked as the DUT issues them.
module tb_ds1302_ctrl;

    localparam int unsigned PollCycles = 100;
    localparam int AckLat = 20;
    localparam int Bound  = 3000;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        logic [55:0] tm;
        logic [55:0] exp_rb;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        set_req;
    logic [55:0] set_time;
    logic        set_ack;
    logic        busy;
    logic [55:0] time_out;
    logic        time_valid;

    ds1302_ctrl_if bus ();

    ds1302_ctrl #(
        .POLL_CYCLES(PollCycles)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_req   (set_req),
        .set_time  (set_time),
        .set_ack   (set_ack),
        .busy      (busy),
        .time_out  (time_out),
        .time_valid(time_valid),
        .io        (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   tv_cnt = 0;
    int   tv_cyc = 0;
    int   ack_cnt = 0;
    int   ack_cyc = 0;
    int   starts = 0;
    int   wr_starts = 0;
    int   tr_hits = 0;
    int   start_cyc [256];
    cmd_t exp_q [$];

    logic [7:0] rtc [7];
    logic [7:0] wp_reg;
    logic [7:0] tr_reg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout after %0d cycles", nm, Bound);
    endtask

    function automatic logic [55:0] model_time();
        return {rtc[6], rtc[5], rtc[4], rtc[3], rtc[2], rtc[1], rtc[0]};
    endfunction

    task automatic push_reads();
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({1'b0, 8'(8'h81 + 2 * i), 8'h00});
        end
    endtask

    task automatic push_set(input logic [55:0] tm);
        logic [55:0] t;
        t = tm;
        exp_q.push_back({1'b1, 8'h8E, 8'h00});
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({1'b1, 8'(8'h80 + 2 * i), t[i*8 +: 8]});
        end
        exp_q.push_back({1'b1, 8'h8E, 8'h80});
    endtask

    task automatic push_boot();
`ifdef DS1302_TRICKLE_INIT_EN
        exp_q.push_back({1'b1, 8'h8E, 8'h00});
        exp_q.push_back({1'b1, 8'h90, 8'hA5});
        exp_q.push_back({1'b1, 8'h8E, 8'h80});
`endif
        push_reads();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tv(input int n0, input string nm);
        int k;
        k = 0;
        while (tv_cnt <= n0 && k < Bound) begin
            step();
            k++;
        end
        if (tv_cnt <= n0) timeout_fail(nm);
    endtask

    task automatic wait_ack(input int n0, input string nm);
        int k;
        k = 0;
        while (ack_cnt <= n0 && k < Bound) begin
            step();
            k++;
        end
        if (ack_cnt <= n0) timeout_fail(nm);
    endtask

    task automatic wait_starts(input int tgt, input int lim, input string nm);
        int k;
        k = 0;
        while (starts < tgt && k < lim) begin
            step();
            k++;
        end
        if (starts < tgt) timeout_fail(nm);
    endtask

    task automatic chk_reset_zero(input string nm);
        chk({nm, "_time"}, time_out, 64'h0);
        chk({nm, "_flags"}, {time_valid, set_ack, busy, bus.cmd_read, bus.cmd_write}, 64'h0);
        chk({nm, "_bus"}, {bus.read_addr, bus.write_addr, bus.write_data}, 64'h0);
    endtask

    // Output-event monitors, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (time_valid) begin
                tv_cnt++;
                tv_cyc = cyc;
            end
            if (set_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
            end
        end
    end

    // DS1302 bus model: checks each command as it starts, acks AckLat cycles later.
    initial begin
        logic       active;
        int         wcnt;
        logic       cur_wr;
        logic [7:0] cur_addr;
        logic [7:0] cur_data;
        cmd_t       e;
        int         ri;
        bus.cmd_read_ack  = 1'b0;
        bus.cmd_write_ack = 1'b0;
        bus.read_data     = 8'h00;
        for (int i = 0; i < 7; i++) rtc[i] = 8'(8'h10 + i);
        wp_reg = 8'h80;
        tr_reg = 8'h00;
        active = 1'b0;
        wcnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.cmd_read_ack  = 1'b0;
            bus.cmd_write_ack = 1'b0;
            if (!(bus.cmd_read || bus.cmd_write)) begin
                active = 1'b0;
            end else if (!active) begin
                active   = 1'b1;
                wcnt     = 0;
                cur_wr   = bus.cmd_write;
                cur_addr = bus.cmd_write ? bus.write_addr : bus.read_addr;
                cur_data = bus.write_data;
                if (starts < 256) start_cyc[starts] = cyc;
                starts++;
                if (cur_wr) wr_starts++;
                if (cur_addr == 8'h90 || cur_addr == 8'h91) tr_hits++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got wr=%0d addr=%0h data=%0h expected none",
                             cur_wr, cur_addr, cur_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_kind", {bus.cmd_read, bus.cmd_write}, e.wr ? 64'h1 : 64'h2);
                    chk("cmd_addr", cur_addr, e.addr);
                    if (e.wr) chk("cmd_data", cur_data, e.data);
                end
            end else begin
                wcnt++;
                if (wcnt == AckLat) begin
                    chk("cmd_stable",
                        {bus.cmd_write, bus.cmd_write ? bus.write_addr : bus.read_addr,
                         cur_wr ? bus.write_data : cur_data},
                        {cur_wr, cur_addr, cur_data});
                    if (cur_wr) begin
                        bus.cmd_write_ack = 1'b1;
                        if (cur_addr == 8'h8E) begin
                            wp_reg = cur_data;
                        end else if (cur_addr == 8'h90) begin
                            chk("wp_open_trickle", wp_reg, 64'h0);
                            tr_reg = cur_data;
                        end else if (cur_addr >= 8'h80 && cur_addr <= 8'h8C && !cur_addr[0]) begin
                            chk("wp_open_time", wp_reg, 64'h0);
                            ri = int'(cur_addr - 8'h80) / 2;
                            rtc[ri] = cur_data;
                        end
                    end else begin
                        bus.cmd_read_ack = 1'b1;
                        if (cur_addr >= 8'h81 && cur_addr <= 8'h8D && cur_addr[0]) begin
                            ri = int'(cur_addr - 8'h81) / 2;
                            bus.read_data = rtc[ri];
                        end else begin
                            bus.read_data = 8'h00;
                        end
                    end
                end
            end
        end
    end

    initial begin
        vec_t vt [3];
        int   tv0;
        int   tvc;
        int   s0;
        int   w0;
        int   a0;
        int   gap;
        logic [55:0] last_set;
        logic [55:0] mid_set;

        vt[0] = '{56'h24_03_07_15_12_34_56, 56'h24_03_07_15_12_34_56};
        vt[1] = '{56'h99_07_12_31_23_59_59, 56'h99_07_12_31_23_59_59};
        vt[2] = '{56'h00_01_01_01_00_00_00, 56'h00_01_01_01_00_00_00};
        mid_set = 56'h25_04_06_30_08_45_01;

        rst      = 1'b0;
        set_req  = 1'b0;
        set_time = '0;
        repeat (3) step();
        chk_reset_zero("reset");

        // Boot and first snapshot.
        push_boot();
        rst = 1'b1;
        wait_tv(0, "first_tv");
        chk("first_time", time_out, 56'h16_15_14_13_12_11_10);
        chk("first_tv_count", tv_cnt, 1);
        chk("first_queue_empty", exp_q.size(), 0);
        chk("busy_in_wait", busy, 0);

        // Poll interval.
        tvc = tv_cyc;
        s0  = starts;
        tv0 = tv_cnt;
        push_reads();
        wait_tv(tv0, "poll_tv");
        gap = start_cyc[s0] - tvc;
        total++;
        if (gap < int'(PollCycles) - 2 || gap > int'(PollCycles) + 2) begin
            bad++;
            $display("FAIL poll_gap: got %0d cycles expected %0d +/- 2", gap, PollCycles);
        end
        chk("poll_time", time_out, 56'h16_15_14_13_12_11_10);
        chk("poll_queue_empty", exp_q.size(), 0);

        // Table of time-set requests, each raised right after a snapshot (in the wait state).
        for (int v = 0; v < 3; v++) begin
            tv0 = tv_cnt;
            a0  = ack_cnt;
            push_set(vt[v].tm);
            push_reads();
            set_time = vt[v].tm;
            set_req  = 1'b1;
            wait_ack(a0, "set_ack");
            set_req = 1'b0;
            s0 = starts;
            chk("busy_after_ack", busy, 1);
            wait_starts(s0 + 1, 3, "readback_immediate");
            wait_tv(tv0, "set_tv");
            chk("set_ack_once", ack_cnt - a0, 1);
            chk("set_tv_once", tv_cnt - tv0, 1);
            chk("set_readback", time_out, vt[v].exp_rb);
            chk("set_queue_empty", exp_q.size(), 0);
        end
        last_set = vt[2].tm;

        // set_req raised during the 3rd read of a poll burst.
        s0 = starts;
        push_reads();
        push_set(mid_set);
        push_reads();
        wait_starts(s0 + 3, Bound, "third_read");
        w0  = wr_starts;
        tv0 = tv_cnt;
        a0  = ack_cnt;
        set_time = mid_set;
        set_req  = 1'b1;
        wait_tv(tv0, "mid_burst_tv");
        chk("no_write_before_tv", wr_starts - w0, 0);
        chk("mid_burst_time", time_out, last_set);
        tv0 = tv_cnt;
        wait_ack(a0, "mid_set_ack");
        set_req = 1'b0;
        wait_tv(tv0, "mid_readback_tv");
        chk("mid_readback", time_out, mid_set);
        chk("mid_queue_empty", exp_q.size(), 0);

        // One-cycle reset during the 4th read of a poll burst.
        s0 = starts;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'h81 + 2 * i), 8'h00});
        wait_starts(s0 + 4, Bound, "fourth_read");
        repeat (5) step();
        chk("pre_reset_queue", exp_q.size(), 0);
        tv0 = tv_cnt;
        rst = 1'b0;
        step();
        chk_reset_zero("midreset");
        rst = 1'b1;
        push_boot();
        wait_tv(tv0, "post_reset_tv");
        chk("post_reset_tv_once", tv_cnt - tv0, 1);
        chk("post_reset_time", time_out, mid_set);
        chk("post_reset_queue", exp_q.size(), 0);

`ifdef DS1302_TRICKLE_INIT_EN
        chk("trickle_reg", tr_reg, 64'hA5);
`else
        chk("no_trickle_access", tr_hits, 0);
`endif
        chk("wp_closed_end", wp_reg, 64'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ds1302_ctrl.md
Name: ds1302_ctrl

Overview:
Transaction scheduler that sits directly above ds1302_io and owns its single-register command interface. It periodically polls the seven DS1302 clock/calendar registers and publishes an atomic BCD time snapshot. It also services user time-set requests as a write-protect-bracketed burst, so user logic never issues raw register commands.

Parameters:
POLL_CYCLES, 5_000_000, clk cycles between the end of one read burst and the start of the next (100 ms at 50 MHz); minimum 1.
TRICKLE_VAL, 8'hA5, value written to trickle-charge register 0x90 when the optional feature is compiled in.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
set_req  in  1  level request to load set_time into the RTC
set_time  in  56  {year,week,month,date,hour,min,sec}, 8-bit BCD each
set_ack  out  1  one-cycle pulse when the set burst is complete
busy  out  1  high whenever not in S_WAIT
time_out  out  56  last complete snapshot, same packing as set_time
time_valid  out  1  one-cycle pulse when time_out updates
cmd_read  out  1  to ds1302_io
cmd_write  out  1  to ds1302_io
read_addr  out  8  to ds1302_io
write_addr  out  8  to ds1302_io
write_data  out  8  to ds1302_io
cmd_read_ack  in  1  from ds1302_io, one-cycle pulse
cmd_write_ack  in  1  from ds1302_io, one-cycle pulse
read_data  in  8  from ds1302_io, valid in the cmd_read_ack cycle

Behaviour:
- All outputs are registered. Reset (rst==0 at posedge) clears every output and internal register to 0, and the state to S_BOOT. ds1302_io is fed ~rst at top level.
- Command handshake:
  - Exactly one of cmd_read/cmd_write is asserted at a time.
  - cmd, addr and data stay stable until the matching ack.
  - cmd drops on the edge after the ack.
  - The next command asserts no earlier than 1 cycle after the drop.
- States:
  - S_BOOT → S_RD_BURST.
  - S_WAIT: timer counts to POLL_CYCLES-1. On expiry → S_RD_BURST. If set_req is pending → S_WP_OFF; set_req has priority over poll expiry in the same cycle.
  - S_RD_BURST: idx 0..6 issues reads at addr 8'h81+2*idx. Each read_data goes to shadow byte idx.
  - S_UPDATE: time_out <= shadow, time_valid pulses → S_WAIT with timer cleared. Then, if set_req is pending, go straight on to S_WP_OFF.
  - S_WP_OFF: write 8E←00 → S_SET.
  - S_SET: idx 0..6 writes addr 8'h80+2*idx, data = set_time byte idx. set_time is captured into a holding register on entry to S_WP_OFF.
  - S_WP_ON: write 8E←80. Then pulse set_ack → S_RD_BURST, so the new time is read back immediately.
- set_req arriving mid-burst: it is latched as pending and serviced only after S_UPDATE. A read burst is never split or interleaved.
- set_req still high after set_ack: treated as a new request. The requester must drop set_req within 1 cycle of set_ack.
- time_out is never partially updated. A reset mid-burst discards the shadow.
- idx is 3 bits and wraps to 0 at the end of each burst.
- Timer width is clog2(POLL_CYCLES).

Optional Feature:
DS1302_TRICKLE_INIT_EN
- Defined: S_BOOT runs a WP-off write (8E←00), then 90←TRICKLE_VAL, then 8E←80, then → S_RD_BURST.
- Undefined: S_BOOT → S_RD_BURST directly, and address 0x90 is never accessed.

Decomposition:
- Package ds1302_pkg:
  - state enum
  - register address constants: SEC_ADDR_W 8'h80, WP_ADDR_W 8'h8E, TRICKLE_ADDR_W 8'h90
  - read-bit offset 1
  - WP_ON 8'h80, WP_OFF 8'h00
  - time-field index constants 0..6
- One natural sub-module, ds1302_poll_timer: a load/expire counter.
- The FSM and command sequencer stay in one module.

Test Plan:
- Reset release with the bus model acking 20 cycles after cmd and returning 8'h10+idx → reads at 81,83,…,8D in order; time_valid pulses once; time_out==56'h16_15_14_13_12_11_10.
- POLL_CYCLES=100 → the next cmd_read at 81 starts 100±2 cycles after the previous time_valid; no command is issued in between.
- set_time=56'h24_03_07_15_12_34_56 during S_WAIT → writes 8E:00, 80:56, 82:34, 84:12, 86:15, 88:07, 8A:03, 8C:24, 8E:80; set_ack pulses once; a read burst follows immediately.
- set_req raised during the 3rd read of a burst → the burst finishes, time_valid pulses, then the 8E:00 write starts; there are no writes before that time_valid.
- rst low for 1 cycle during the 4th read → all outputs are 0 next cycle; time_valid does not pulse; after release a fresh burst restarts at 81.
- With DS1302_TRICKLE_INIT_EN, after reset → 8E:00, 90:A5, 8E:80 precede the first read at 81.
